perceptron_trainer: RTL and testbench
=====================================

// Module: perceptron_trainer
// PURPOSE
//  Online perceptron-rule trainer; sits beside perceptron, downstream of its 1-bit result.
//  Per labelled sample: loads IN1/IN2 into the perceptron input regs, waits for the result,
//  compares it with the target and, on misclassification, issues one weight update
//  w_i += lr*err*x_i (lr = 2^-LR_SHIFT). Also keeps sample and error counters for the host.
// PARAMETERS
//  fp_integer_width  4   integer bits of signed fixed-point values
//  fp_fract_width    12  fraction bits; fp_width = sum, must be <= 16
//  LR_SHIFT          2   learning rate = 2^-LR_SHIFT (arithmetic right shift of x)
//  SETTLE_CYCLES     2   cycles waited after in_ld before sampling result (>=1)
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         async reset, active low
//  start        in   1         accept one labelled sample (ignored while busy)
//  sample_in1   in   fp_width  input 1, signed fixed point
//  sample_in2   in   fp_width  input 2, signed fixed point
//  target       in   1         expected class
//  result       in   1         perceptron output
//  weight1      in   fp_width  current perceptron weight 1
//  weight2      in   fp_width  current perceptron weight 2
//  clear        in   1         zero sample_count/err_count
//  in1_out      out  fp_width  latched sample_in1 to perceptron input reg
//  in2_out      out  fp_width  latched sample_in2
//  in_ld        out  1         1-cycle load strobe for perceptron inputs
//  weight1_new  out  fp_width  updated weight 1
//  weight2_new  out  fp_width  updated weight 2
//  weight_ld    out  1         1-cycle weight load strobe (both weights)
//  busy         out  1         high outside IDLE
//  done         out  1         1-cycle pulse at end of sample
//  miss         out  1         class of last sample was wrong; valid with done, held
//  sample_count out  16        samples processed, saturating
//  err_count    out  16        misclassifications, saturating
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0. Reset mid-sample aborts it; no strobe follows.
//  FSM: IDLE -start-> LOAD_IN -> SETTLE(SETTLE_CYCLES) -> EVAL -> (miss ? UPDATE : DONE);
//   UPDATE -> DONE -> IDLE.
//  Timing (start sampled at end of cycle 0, S=SETTLE_CYCLES):
//   cycle 1 LOAD_IN: in_ld=1, in1_out/in2_out = start-cycle samples, target latched.
//   cycles 2..S+1 SETTLE; cycle S+2 EVAL: result sampled; miss, weight*_new registered.
//   miss: cycle S+3 UPDATE weight_ld=1; cycle S+4 done=1. hit: cycle S+3 done=1, no weight_ld.
//  start while busy: ignored, no queueing. start held high: new sample accepted in IDLE
//   cycle after done.
//  Inputs weight1/2 sampled in EVAL; sample_in*/target sampled only on accepted start.
//  Arithmetic: d_i = x_i >>> LR_SHIFT (sign-preserving); err = target - result.
//   target=1,result=0: w_i+d_i; target=0,result=1: w_i-d_i; computed in fp_width+1 bits.
//  Counters: at EVAL sample_count+1, err_count+1 if miss; both saturate at 16'hFFFF.
//   clear in any cycle zeroes both; clear same cycle as increment -> clear wins (result 0).
//  weight*_new hold last value between updates; in*_out hold last sample.
// CONFIGURATION
//  PERCEPTRON_TRAINER_SAT_EN defined: weight sum clamped to [-2^(fp_width-1), 2^(fp_width-1)-1].
//  Not defined: sum truncated to fp_width bits (two's-complement wrap).
// TESTING (4.12 format, LR_SHIFT=2, S=2; cycle numbers relative to start cycle 0)
//  1 w1=0x1000,w2=0x0000,in1=0x1000,in2=0x0800,target=1,result=1 -> in_ld@1, done@5,
//    no weight_ld, miss=0, sample_count=1, err_count=0.
//  2 same, result=0 -> weight_ld@5 only, w1_new=0x1400, w2_new=0x0200, done@6, err_count=1.
//  3 w1=0x1000,in1=0xF000(-1.0),target=0,result=1 -> w1_new=0x1400 (minus negative delta).
//  4 w1=0x7F00,in1=0x7000,target=1,result=0 -> SAT_EN: w1_new=0x7FFF; else w1_new=0x9B00.
//  5 start pulsed @3 during busy -> ignored, one done only; clear asserted in EVAL of a miss
//    -> err_count=0, sample_count=0.
//  6 rst_n low during SETTLE -> busy=0, all outputs 0; no weight_ld/done after release.

Source files
------------

// File: rtl/perceptron_trainer.sv
// Online perceptron-rule trainer: loads a sample, waits for the perceptron result, and on a miss
// issues one weight update. Define PERCEPTRON_TRAINER_SAT_EN to saturate updated weights instead of wrapping.
module perceptron_trainer #(
  parameter int fp_integer_width = 4,
  parameter int fp_fract_width   = 12,
  parameter int LR_SHIFT         = 2,
  parameter int SETTLE_CYCLES    = 2,
  localparam int fp_width        = fp_integer_width + fp_fract_width
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [fp_width-1:0] sample_in1,
  input  logic [fp_width-1:0] sample_in2,
  input  logic                target,
  input  logic                result,
  input  logic [fp_width-1:0] weight1,
  input  logic [fp_width-1:0] weight2,
  input  logic                clear,
  output logic [fp_width-1:0] in1_out,
  output logic [fp_width-1:0] in2_out,
  output logic                in_ld,
  output logic [fp_width-1:0] weight1_new,
  output logic [fp_width-1:0] weight2_new,
  output logic                weight_ld,
  output logic                busy,
  output logic                done,
  output logic                miss,
  output logic [15:0]         sample_count,
  output logic [15:0]         err_count
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_EVAL   = 3'd3;
  localparam logic [2:0] ST_UPDATE = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [2:0]          state_r;
  logic [CNT_W-1:0]    settle_cnt_r;
  logic                target_r;
  logic                miss_s;
  logic [fp_width-1:0] w1_upd_s;
  logic [fp_width-1:0] w2_upd_s;

  // w +/- (x >>> LR_SHIFT) in one extra bit, then clamped or wrapped back to fp_width
  function automatic logic [fp_width-1:0] update_weight(
    input logic [fp_width-1:0] w,
    input logic [fp_width-1:0] x,
    input logic                add
  );
    logic signed [fp_width:0] wx;
    logic signed [fp_width:0] xx;
    logic signed [fp_width:0] dx;
    logic signed [fp_width:0] sum;
    wx  = {w[fp_width-1], w};
    xx  = {x[fp_width-1], x};
    dx  = xx >>> LR_SHIFT;
    if (add) begin
      sum = wx + dx;
    end else begin
      sum = wx - dx;
    end
`ifdef PERCEPTRON_TRAINER_SAT_EN
    if (sum[fp_width] != sum[fp_width-1]) begin
      if (sum[fp_width]) begin
        return {1'b1, {(fp_width-1){1'b0}}};
      end else begin
        return {1'b0, {(fp_width-1){1'b1}}};
      end
    end else begin
      return sum[fp_width-1:0];
    end
`else
    return sum[fp_width-1:0];
`endif
  endfunction

  // Misclassification flag and candidate weights; target=1 means err=+1 (add), else subtract
  always_comb begin
    miss_s   = (result != target_r);
    w1_upd_s = update_weight(weight1, in1_out, target_r);
    w2_upd_s = update_weight(weight2, in2_out, target_r);
  end

  // Sample sequencing FSM with registered strobes and datapath outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {CNT_W{1'b0}};
      target_r     <= 1'b0;
      in1_out      <= {fp_width{1'b0}};
      in2_out      <= {fp_width{1'b0}};
      in_ld        <= 1'b0;
      weight1_new  <= {fp_width{1'b0}};
      weight2_new  <= {fp_width{1'b0}};
      weight_ld    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      miss         <= 1'b0;
    end else begin
      in_ld     <= 1'b0;
      weight_ld <= 1'b0;
      done      <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_LOAD;
            in1_out  <= sample_in1;
            in2_out  <= sample_in2;
            target_r <= target;
            in_ld    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_r      <= ST_SETTLE;
          settle_cnt_r <= {CNT_W{1'b0}};
        end
        ST_SETTLE: begin
          if (settle_cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
            state_r <= ST_EVAL;
          end else begin
            settle_cnt_r <= settle_cnt_r + CNT_W'(1);
          end
        end
        ST_EVAL: begin
          miss <= miss_s;
          if (miss_s) begin
            weight1_new <= w1_upd_s;
            weight2_new <= w2_upd_s;
            weight_ld   <= 1'b1;
            state_r     <= ST_UPDATE;
          end else begin
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_UPDATE: begin
          done    <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating host counters; clear overrides a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count <= 16'd0;
      err_count    <= 16'd0;
    end else if (clear) begin
      sample_count <= 16'd0;
      err_count    <= 16'd0;
    end else if (state_r == ST_EVAL) begin
      if (sample_count != 16'hFFFF) begin
        sample_count <= sample_count + 16'd1;
      end
      if (miss_s && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Self-checking bench for perceptron_trainer: per-sample behavioural model plus directed literal pins.
module tb_perceptron_trainer;
  localparam int S  = 2;
  localparam int LR = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] sample_in1 = 16'd0;
  logic [15:0] sample_in2 = 16'd0;
  logic        target = 1'b0;
  logic        result = 1'b0;
  logic [15:0] weight1 = 16'd0;
  logic [15:0] weight2 = 16'd0;
  logic        clear = 1'b0;
  logic [15:0] in1_out, in2_out, weight1_new, weight2_new, sample_count, err_count;
  logic        in_ld, weight_ld, busy, done, miss;

  perceptron_trainer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sample_in1(sample_in1), .sample_in2(sample_in2),
    .target(target), .result(result), .weight1(weight1), .weight2(weight2), .clear(clear),
    .in1_out(in1_out), .in2_out(in2_out), .in_ld(in_ld), .weight1_new(weight1_new),
    .weight2_new(weight2_new), .weight_ld(weight_ld), .busy(busy), .done(done), .miss(miss),
    .sample_count(sample_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // model state (what the outputs must hold)
  logic [15:0] m_in1 = 16'd0, m_in2 = 16'd0, m_w1n = 16'd0, m_w2n = 16'd0, m_sc = 16'd0, m_ec = 16'd0;
  logic        m_miss = 1'b0;
  // expected strobes for the current cycle
  logic        e_busy = 1'b0, e_in_ld = 1'b0, e_wld = 1'b0, e_done = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_upd(input logic [15:0] w, input logic [15:0] x, input bit add);
    int wi, xi, di, s;
    wi = int'($signed(w));
    xi = int'($signed(x));
    di = xi >>> LR;
    s  = add ? wi + di : wi - di;
`ifdef PERCEPTRON_TRAINER_SAT_EN
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_in1 = 16'd0; m_in2 = 16'd0; m_w1n = 16'd0; m_w2n = 16'd0;
    m_sc = 16'd0; m_ec = 16'd0; m_miss = 1'b0;
  endtask

  // apply what the clock edge into sample cycle c must have done (c<0: idle cycle)
  task automatic enter(input int c, input logic [15:0] in1, input logic [15:0] in2,
                       input logic [15:0] w1, input logic [15:0] w2, input bit tgt, input bit mis);
    if (clear) begin
      m_sc = 16'd0;
      m_ec = 16'd0;
    end else if (c == S + 3) begin
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
      if (mis && m_ec != 16'hFFFF) m_ec = m_ec + 16'd1;
    end
    if (c == 1) begin
      m_in1 = in1;
      m_in2 = in2;
    end
    if (c == S + 3) begin
      m_miss = mis;
      if (mis) begin
        m_w1n = m_upd(w1, in1, tgt);
        m_w2n = m_upd(w2, in2, tgt);
      end
    end
  endtask

  task automatic set_exp(input int c, input int last, input bit mis);
    e_busy  = (c >= 1);
    e_in_ld = (c == 1);
    e_wld   = mis && (c == S + 3);
    e_done  = (c == last);
  endtask

  // the single per-cycle compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {15'd0, busy}, {15'd0, e_busy});
      chk("in_ld", {15'd0, in_ld}, {15'd0, e_in_ld});
      chk("weight_ld", {15'd0, weight_ld}, {15'd0, e_wld});
      chk("done", {15'd0, done}, {15'd0, e_done});
      chk("miss", {15'd0, miss}, {15'd0, m_miss});
      chk("in1_out", in1_out, m_in1);
      chk("in2_out", in2_out, m_in2);
      chk("weight1_new", weight1_new, m_w1n);
      chk("weight2_new", weight2_new, m_w2n);
      chk("sample_count", sample_count, m_sc);
      chk("err_count", err_count, m_ec);
    end
  end

  // noise: 0 none, 1 start pulse in cycle 3, 2 random start while busy
  task automatic do_sample(input logic [15:0] in1, input logic [15:0] in2, input logic [15:0] w1,
                           input logic [15:0] w2, input bit tgt, input bit res, input int noise,
                           input int clear_c, input int abort_c);
    bit mis;
    int last;
    mis  = (tgt != res);
    last = mis ? S + 4 : S + 3;
    for (int c = 0; c <= last; c++) begin
      enter(c, in1, in2, w1, w2, tgt, mis);
      if (c == abort_c) begin
        rst_n = 1'b0;
        start = 1'b0;
        clear = 1'b0;
        #1;
        model_reset();
        set_exp(-1, -2, 1'b0);
        step();
        rst_n = 1'b1;
        return;
      end
      set_exp(c, last, mis);
      if (c == 0) start = 1'b1;
      else if (noise == 2) start = 1'($urandom_range(0, 1));
      else start = (noise == 1) && (c == 3);
      sample_in1 = (c == 0) ? in1 : 16'($urandom);
      sample_in2 = (c == 0) ? in2 : 16'($urandom);
      target     = (c == 0) ? tgt : 1'($urandom_range(0, 1));
      result     = (c == S + 2) ? res : 1'($urandom_range(0, 1));
      weight1    = (c == S + 2) ? w1 : 16'($urandom);
      weight2    = (c == S + 2) ? w2 : 16'($urandom);
      clear      = (c == clear_c);
      step();
    end
  endtask

  task automatic idle(input int n, input bit rclr);
    for (int i = 0; i < n; i++) begin
      enter(-1, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
      set_exp(-1, -2, 1'b0);
      start = 1'b0;
      clear = rclr ? ($urandom_range(0, 7) == 0) : 1'b0;
      step();
    end
  endtask

  initial begin
    model_reset();
    set_exp(-1, -2, 1'b0);
    chk_en = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    idle(2, 1'b0);

    chk("model_pin_sub", m_upd(16'h1000, 16'hF000, 1'b0), 16'h1400);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    chk("model_pin_ovf", m_upd(16'h7F00, 16'h7000, 1'b1), 16'h7FFF);
`else
    chk("model_pin_ovf", m_upd(16'h7F00, 16'h7000, 1'b1), 16'h9B00);
`endif

    // 1: hit
    do_sample(16'h1000, 16'h0800, 16'h1000, 16'h0000, 1'b1, 1'b1, 0, -1, -1);
    chk("t1_miss", {15'd0, miss}, 16'd0);
    chk("t1_samples", sample_count, 16'd1);
    chk("t1_errors", err_count, 16'd0);
    // 2: miss, add
    do_sample(16'h1000, 16'h0800, 16'h1000, 16'h0000, 1'b1, 1'b0, 0, -1, -1);
    chk("t2_w1", weight1_new, 16'h1400);
    chk("t2_w2", weight2_new, 16'h0200);
    chk("t2_errors", err_count, 16'd1);
    // 3: miss, subtract negative delta
    do_sample(16'hF000, 16'h0400, 16'h1000, 16'h0000, 1'b0, 1'b1, 0, -1, -1);
    chk("t3_w1", weight1_new, 16'h1400);
    chk("t3_w2", weight2_new, 16'hFF00);
    // 4: overflow
    do_sample(16'h7000, 16'h0000, 16'h7F00, 16'h0100, 1'b1, 1'b0, 0, -1, -1);
`ifdef PERCEPTRON_TRAINER_SAT_EN
    chk("t4_w1", weight1_new, 16'h7FFF);
`else
    chk("t4_w1", weight1_new, 16'h9B00);
`endif
    chk("t4_samples", sample_count, 16'd4);
    // 5: start while busy ignored, clear during EVAL of a miss wins
    do_sample(16'h2000, 16'h0100, 16'h0300, 16'h0400, 1'b1, 1'b0, 1, S + 2, -1);
    chk("t5_samples", sample_count, 16'd0);
    chk("t5_errors", err_count, 16'd0);
    idle(1, 1'b0);
    // 6: reset during SETTLE
    do_sample(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1, 1'b0, 0, -1, 3);
    chk("t6_busy", {15'd0, busy}, 16'd0);
    idle(5, 1'b0);

    for (int k = 0; k < 150; k++) begin
      do_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2,
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1,
                ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 4)) : -1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), 1'b1);
    end
    idle(2, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
